// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory (req/gnt/rvalid) and hands fetched words to decode.
// A one-entry skid buffer catches a response that lands while decode stalls.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Gnt,
  input  logic        Imem_Rvalid,
  input  logic [31:0] Imem_Rdata,
  input  logic        Stall_In,
  input  logic        Redirect_In,
  input  logic [31:0] Redirect_PC,
  output logic [31:0] Inst_Out,
  output logic [31:0] PC_Out,
  output logic        Inst_Valid_Out
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } slot_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, fetch_addr, fetch_n, addr_n;
  logic        req_n;
  slot_t       out_q, out_n, skid_q, skid_n;
  logic        vld_q, vld_n, skid_vld, skid_vld_n;
  logic        grant, resp, free;

  // Req is only ever high in IDLE, so a grant always belongs to IDLE.
  assign grant = Imem_Req & Imem_Gnt;
  assign resp  = (state == WAIT) & Imem_Rvalid;
  assign free  = ~vld_q | ~Stall_In;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state: a redirect turns any fetch still in flight into one to drop.
  // A response arriving in DROP always ends it, even alongside a new redirect,
  // because no further response will ever come for that fetch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant) state_n = Redirect_In ? DROP : WAIT;
      WAIT:    if (Imem_Rvalid) state_n = IDLE;
               else if (Redirect_In) state_n = DROP;
      DROP:    if (Imem_Rvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values for PC, output register, skid buffer and memory request
  always_comb begin
    pc_n       = pc;
    fetch_n    = fetch_addr;
    out_n      = out_q;
    vld_n      = vld_q;
    skid_n     = skid_q;
    skid_vld_n = skid_vld;
    if (grant) begin
      fetch_n = pc;
      pc_n    = pc + STEP;
    end
    if (Redirect_In) begin
      vld_n      = 1'b0;
      skid_vld_n = 1'b0;
      pc_n       = {Redirect_PC[31:2], 2'b00};
    end else if (free) begin
      // Skid entry is older than any fresh response, so it drains first.
      if (skid_vld) begin
        out_n      = skid_q;
        vld_n      = 1'b1;
        skid_vld_n = 1'b0;
        if (resp) begin
          skid_n     = {Imem_Rdata, fetch_addr};
          skid_vld_n = 1'b1;
        end
      end else if (resp) begin
        out_n = {Imem_Rdata, fetch_addr};
        vld_n = 1'b1;
      end else begin
        vld_n = 1'b0;
      end
    end else if (resp) begin
      skid_n     = {Imem_Rdata, fetch_addr};
      skid_vld_n = 1'b1;
    end
    // Request whenever we will sit in IDLE with room to land the answer.
    req_n  = (state_n == IDLE) & ~skid_vld_n & ~Redirect_In;
    addr_n = req_n ? pc_n : Imem_Addr;
  end

  // Datapath and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      Imem_Req   <= 1'b0;
      Imem_Addr  <= RESET_PC;
      out_q      <= '0;
      vld_q      <= 1'b0;
      skid_q     <= '0;
      skid_vld   <= 1'b0;
    end else begin
      pc         <= pc_n;
      fetch_addr <= fetch_n;
      Imem_Req   <= req_n;
      Imem_Addr  <= addr_n;
      out_q      <= out_n;
      vld_q      <= vld_n;
      skid_q     <= skid_n;
      skid_vld   <= skid_vld_n;
    end
  end

  assign Inst_Out       = out_q.inst;
  assign PC_Out         = out_q.pc;
  assign Inst_Valid_Out = vld_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a randomized memory/decode/execute environment with a
// program-order reference model (expected fetch address and expected PC of
// the next instruction decode accepts), plus directed corner sequences.
module tb_inst_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Gnt;
  logic        Imem_Rvalid;
  logic [31:0] Imem_Rdata;
  logic        Stall_In;
  logic        Redirect_In;
  logic [31:0] Redirect_PC;
  logic [31:0] Inst_Out;
  logic [31:0] PC_Out;
  logic        Inst_Valid_Out;

  inst_fetch dut (
    .Clk(Clk), .Reset(Reset),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Gnt(Imem_Gnt),
    .Imem_Rvalid(Imem_Rvalid), .Imem_Rdata(Imem_Rdata),
    .Stall_In(Stall_In), .Redirect_In(Redirect_In), .Redirect_PC(Redirect_PC),
    .Inst_Out(Inst_Out), .PC_Out(PC_Out), .Inst_Valid_Out(Inst_Valid_Out)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  // environment knobs (percentages / response delay range in cycles)
  int p_gnt, p_stall, p_redir, min_dly, max_dly;
  bit spur_en;
  // reference model
  logic [31:0] exp_pc, nxt_fetch, pend_addr, last_pc, prev_addr;
  bit          pend, prev_req, prev_issue, rhythm, saw0;
  int          dly, consumed, issues, last_cons;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare the current cycle against program order, then advance the model
  // as the coming clock edge will.
  task automatic eval();
    bit issue;
    issue = Imem_Req && Imem_Gnt && !Reset;
    if (!Reset) begin
      if (pend) check("one_outstanding", 32'(Imem_Req), 32'd0);
      if (Imem_Req && prev_req && !prev_issue) check("addr_stable", Imem_Addr, prev_addr);
      if (issue) begin
        check("fetch_addr", Imem_Addr, nxt_fetch);
        if (Imem_Addr == 32'd0) saw0 = 1'b1;
        nxt_fetch = nxt_fetch + 32'd4;
        pend      = 1'b1;
        pend_addr = Imem_Addr;
        dly       = $urandom_range(max_dly, min_dly);
        issues++;
      end
      if (Inst_Valid_Out && !Stall_In && !Redirect_In) begin
        check("pc_out", PC_Out, exp_pc);
        check("inst_out", Inst_Out, exp_pc + 32'h100);
        if (rhythm && last_cons >= 0) check("rhythm", 32'(cyc - last_cons), 32'd2);
        last_cons = cyc;
        last_pc   = PC_Out;
        exp_pc    = exp_pc + 32'd4;
        consumed++;
      end
      if (Redirect_In) begin
        exp_pc    = {Redirect_PC[31:2], 2'b00};
        nxt_fetch = {Redirect_PC[31:2], 2'b00};
      end
    end
    prev_req   = Imem_Req && !Reset;
    prev_issue = issue;
    prev_addr  = Imem_Addr;
    if (Reset) begin
      exp_pc    = 32'd0;
      nxt_fetch = 32'd0;
      pend      = 1'b0;
    end
  endtask

  // Drive the next cycle's inputs: memory answers its pending fetch after the
  // chosen delay; everything else is random per the knobs.
  task automatic pick();
    if (pend) begin
      if (dly == 0) begin
        Imem_Rvalid = 1'b1;
        Imem_Rdata  = pend_addr + 32'h100;
        pend        = 1'b0;
      end else begin
        dly--;
        Imem_Rvalid = 1'b0;
        Imem_Rdata  = $urandom;
      end
    end else begin
      Imem_Rvalid = spur_en && ($urandom_range(99, 0) < 10);
      Imem_Rdata  = $urandom;
    end
    Imem_Gnt    = $urandom_range(99, 0) < p_gnt;
    Stall_In    = $urandom_range(99, 0) < p_stall;
    Redirect_In = $urandom_range(99, 0) < p_redir;
    if ($urandom_range(7, 0) == 0) Redirect_PC = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    else                           Redirect_PC = $urandom & 32'h0000_3FFF;
  endtask

  task automatic step();
    eval();
    @(posedge Clk);
    #1;
    cyc++;
    pick();
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_req"},   32'(Imem_Req), 32'd0);
    check({tag, "_addr"},  Imem_Addr, 32'd0);
    check({tag, "_inst"},  Inst_Out, 32'd0);
    check({tag, "_pc"},    PC_Out, 32'd0);
    check({tag, "_valid"}, 32'(Inst_Valid_Out), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Imem_Gnt = 1'b0; Imem_Rvalid = 1'b0; Imem_Rdata = '0;
    Stall_In = 1'b0; Redirect_In = 1'b0; Redirect_PC = '0;
    p_gnt = 100; p_stall = 0; p_redir = 0; min_dly = 0; max_dly = 0; spur_en = 0;
    exp_pc = 0; nxt_fetch = 0; pend = 0; dly = 0; pend_addr = 0; last_pc = 0;
    prev_addr = 0; prev_req = 0; prev_issue = 0; rhythm = 0; saw0 = 0;
    consumed = 0; issues = 0; last_cons = -1;

    // reset state and straight-line fetch rhythm
    repeat (2) step();
    chk_reset_outs("rst");
    Reset = 1'b0;
    step();
    check("first_req", 32'(Imem_Req), 32'd1);
    check("first_addr", Imem_Addr, 32'd0);
    rhythm = 1;
    repeat (12) step();
    rhythm = 0;
    check("rhythm_cnt", 32'(consumed), 32'd5);

    // grant withheld for three cycles
    p_gnt = 0;
    Reset = 1'b1; step(); Reset = 1'b0;
    step();
    repeat (3) begin
      step();
      check("gnt_hold_req", 32'(Imem_Req), 32'd1);
      check("gnt_hold_addr", Imem_Addr, 32'd0);
    end
    p_gnt = 100; Imem_Gnt = 1'b1;
    repeat (6) step();

    // stall with a response landing: exactly one more fetch, then none
    for (int i = 0; i < 20 && !Inst_Valid_Out; i++) step();
    check("stall_wait", 32'(Inst_Valid_Out), 32'd1);
    p_stall = 100; Stall_In = 1'b1; issues = 0;
    repeat (8) step();
    check("stall_issues", 32'(issues), 32'd1);
    check("stall_hold_valid", 32'(Inst_Valid_Out), 32'd1);
    p_stall = 0; Stall_In = 1'b0;
    repeat (10) step();

    // redirect while waiting for a response
    min_dly = 2; max_dly = 2;
    for (int i = 0; i < 30 && !pend; i++) step();
    check("wait_issue", 32'(pend), 32'd1);
    Redirect_In = 1'b1; Redirect_PC = 32'h0000_2002;
    begin
      int c0;
      c0 = consumed;
      step();
      check("redir_valid", 32'(Inst_Valid_Out), 32'd0);
      for (int i = 0; i < 40 && consumed == c0; i++) step();
      check("redir_first_pc", last_pc, 32'h0000_2000);
    end

    // redirect coinciding with a grant, then with a response
    min_dly = 0; max_dly = 1;
    for (int i = 0; i < 30 && !Imem_Req; i++) step();
    check("req_seen", 32'(Imem_Req), 32'd1);
    Imem_Gnt = 1'b1; Redirect_In = 1'b1; Redirect_PC = 32'h0000_3000;
    repeat (10) step();
    for (int i = 0; i < 30 && !Imem_Rvalid; i++) step();
    check("rvalid_seen", 32'(Imem_Rvalid), 32'd1);
    Redirect_In = 1'b1; Redirect_PC = 32'h0000_4001;
    repeat (10) step();

    // PC wrap at the top of the address space
    saw0 = 0;
    Redirect_In = 1'b1; Redirect_PC = 32'hFFFF_FFF8;
    repeat (14) step();
    check("wrap_seen", 32'(saw0), 32'd1);

    // reset in the middle of a fetch; the late response must vanish
    min_dly = 3; max_dly = 3;
    for (int i = 0; i < 30 && !pend; i++) step();
    check("wait_issue2", 32'(pend), 32'd1);
    Reset = 1'b1;
    step();
    chk_reset_outs("rst_wait");
    Reset = 1'b0; p_gnt = 0; Imem_Gnt = 1'b0;
    step();
    Imem_Rvalid = 1'b1; Imem_Rdata = 32'hDEAD_BEEF;
    step();
    repeat (3) begin
      step();
      check("late_rvalid", 32'(Inst_Valid_Out), 32'd0);
    end

    // randomized traffic
    begin
      int c0;
      c0 = consumed;
      p_gnt = 60; p_stall = 30; p_redir = 4; min_dly = 0; max_dly = 3; spur_en = 1;
      repeat (3000) step();
      check("progress", 32'(consumed > c0 + 100), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
